// File: rtl/output_buffer_ctrl_pkg.sv
// rtl/output_buffer_ctrl_pkg.sv - shared constants and state encoding for the A-buffer output sequencer
package output_buffer_ctrl_pkg;

   // Datapath geometry
   localparam int FEATURE_WIDTH = 8;
   localparam int A_BUFFER_NUM  = 25;
   localparam int OBUF_CNT_W    = 24;

   // Layer computation type
   localparam logic [7:0] NORMAL_CONV_MODE = 8'h01;
   localparam logic [7:0] DW_CONV_MODE     = 8'h02;

   // Kernel size selection
   localparam logic [1:0] KERNEL_SIZE_5_MODE = 2'd0;
   localparam logic [1:0] KERNEL_SIZE_3_MODE = 2'd1;
   localparam logic [1:0] KERNEL_SIZE_1_MODE = 2'd2;

   // Rows drained per output column group in the read phase
   localparam int ROW_NUM_3 = 4;
   localparam int ROW_NUM_5 = 5;

   // Rows written per column in the write phase
   localparam int WR_ROW_NUM_3 = 2;
   localparam int WR_ROW_NUM_5 = 5;

   // Channels interleaved per beat group
   localparam int CH_NUM_CONV = 8;
   localparam int CH_NUM_DW   = 4;

   // Columns per read group (one per buffer bank) and per conv-1 write beat
   localparam int RD_COL_GROUP = 25;
   localparam int K1_COL_GROUP = 5;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CFG,
      ST_WR_RST,
      ST_WRITE,
      ST_RD_RST,
      ST_GAP,
      ST_READ,
      ST_DONE
   } obc_state_e;

endpackage

// File: rtl/output_buffer_ctrl_beat_calc.sv
// rtl/output_buffer_ctrl_beat_calc.sv - combinational write/read beat totals and config check
module obuf_beat_calc #(
   parameter int CNT_W = 24
) (
   input  logic [15:0]      width_i,
   input  logic [1:0]       kn_size_mode_i,
   input  logic [7:0]       com_type_i,
   output logic [CNT_W-1:0] wr_total_o,
   output logic [CNT_W-1:0] rd_total_o,
   output logic             err_o
);
   import output_buffer_ctrl_pkg::*;

   logic [CNT_W-1:0] w_ext;
   logic [CNT_W-1:0] w_div5;
   logic [CNT_W-1:0] w_div25;
   logic [CNT_W-1:0] rd_rows;
   logic [CNT_W-1:0] rd_chans;

   // Totals from the layer shape; all divisions are by constants and round up
   always_comb begin
      w_ext      = CNT_W'(width_i);
      w_div5     = (w_ext + CNT_W'(K1_COL_GROUP - 1)) / CNT_W'(K1_COL_GROUP);
      w_div25    = (w_ext + CNT_W'(RD_COL_GROUP - 1)) / CNT_W'(RD_COL_GROUP);
      rd_rows    = (kn_size_mode_i == KERNEL_SIZE_3_MODE) ? CNT_W'(ROW_NUM_3) : CNT_W'(ROW_NUM_5);
      rd_chans   = (com_type_i == DW_CONV_MODE) ? CNT_W'(CH_NUM_DW) : CNT_W'(CH_NUM_CONV);
      rd_total_o = rd_rows * w_div25 * rd_chans;
      wr_total_o = '0;
      err_o      = 1'b0;
      if (com_type_i == NORMAL_CONV_MODE) begin
         case (kn_size_mode_i)
            KERNEL_SIZE_5_MODE: wr_total_o = w_ext * CNT_W'(WR_ROW_NUM_5 * CH_NUM_CONV);
            KERNEL_SIZE_3_MODE: wr_total_o = w_ext * CNT_W'(WR_ROW_NUM_3 * CH_NUM_CONV);
            KERNEL_SIZE_1_MODE: wr_total_o = w_div5 * CNT_W'(CH_NUM_CONV);
            default:            err_o      = 1'b1;
         endcase
      end else if (com_type_i == DW_CONV_MODE) begin
         // Depthwise has no 1x1 form; an unknown kernel code is also rejected
         case (kn_size_mode_i)
            KERNEL_SIZE_5_MODE: wr_total_o = w_ext * CNT_W'(WR_ROW_NUM_5);
            KERNEL_SIZE_3_MODE: wr_total_o = w_ext * CNT_W'(WR_ROW_NUM_3);
            default:            err_o      = 1'b1;
         endcase
      end else begin
         err_o = 1'b1;
      end
      if (width_i == 16'd0) begin
         err_o = 1'b1;
      end
   end

endmodule

// File: rtl/output_buffer_ctrl.sv
// rtl/output_buffer_ctrl.sv - write/drain sequencer between the PE result bus and the A-buffer output module
module output_buffer_ctrl #(
   parameter int FEATURE_WIDTH = output_buffer_ctrl_pkg::FEATURE_WIDTH,
   parameter int BUFFER_NUM    = output_buffer_ctrl_pkg::A_BUFFER_NUM,
   parameter int CNT_W         = output_buffer_ctrl_pkg::OBUF_CNT_W
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                start,
   input  logic                                clear,
   input  logic [15:0]                         layer_width,
   input  logic [1:0]                          kn_size_mode,
   input  logic [7:0]                          com_type,
   input  logic                                first_iter,
   input  logic                                res_valid,
   input  logic [BUFFER_NUM*FEATURE_WIDTH-1:0] res_data,
   input  logic                                rd_ready,
   output logic                                cnt_rst,
   output logic                                initial_iteration,
   output logic                                wr_rd_mode,
   output logic [4:0]                          current_channel_NO,
   output logic                                rd_out_en,
   output logic [BUFFER_NUM*FEATURE_WIDTH-1:0] buf_data_in,
   output logic                                busy,
   output logic                                done,
   output logic                                cfg_err
);
   import output_buffer_ctrl_pkg::*;

   localparam int DW = BUFFER_NUM * FEATURE_WIDTH;

   obc_state_e       state_q, state_d;
   logic [15:0]      width_q, width_d;
   logic [1:0]       kn_q, kn_d;
   logic [7:0]       com_q, com_d;
   logic             first_q, first_d;
   logic [CNT_W-1:0] wr_total_q, wr_total_d;
   logic [CNT_W-1:0] rd_total_q, rd_total_d;
   logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;
   logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;
   logic             gap_q, gap_d;
   logic [4:0]       chan_q, chan_d;
   logic [DW-1:0]    data_q, data_d;
   logic             rd_en_q, rd_en_d;
   logic             err_q, err_d;

   logic [CNT_W-1:0] calc_wr_total;
   logic [CNT_W-1:0] calc_rd_total;
   logic             calc_err;

   obuf_beat_calc #(
      .CNT_W (CNT_W)
   ) u_beat_calc (
      .width_i        (width_q),
      .kn_size_mode_i (kn_q),
      .com_type_i     (com_q),
      .wr_total_o     (calc_wr_total),
      .rd_total_o     (calc_rd_total),
      .err_o          (calc_err)
   );

   // State, latched config, counters and the registered beat/strobe outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_IDLE;
         width_q    <= '0;
         kn_q       <= '0;
         com_q      <= '0;
         first_q    <= 1'b0;
         wr_total_q <= '0;
         rd_total_q <= '0;
         wr_cnt_q   <= '0;
         rd_cnt_q   <= '0;
         gap_q      <= 1'b0;
         chan_q     <= '0;
         data_q     <= '0;
         rd_en_q    <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         width_q    <= width_d;
         kn_q       <= kn_d;
         com_q      <= com_d;
         first_q    <= first_d;
         wr_total_q <= wr_total_d;
         rd_total_q <= rd_total_d;
         wr_cnt_q   <= wr_cnt_d;
         rd_cnt_q   <= rd_cnt_d;
         gap_q      <= gap_d;
         chan_q     <= chan_d;
         data_q     <= data_d;
         rd_en_q    <= rd_en_d;
         err_q      <= err_d;
      end
   end

   // Next-state: layer sequencing, beat tagging and read strobes; clear overrides all
   always_comb begin
      state_d    = state_q;
      width_d    = width_q;
      kn_d       = kn_q;
      com_d      = com_q;
      first_d    = first_q;
      wr_total_d = wr_total_q;
      rd_total_d = rd_total_q;
      wr_cnt_d   = wr_cnt_q;
      rd_cnt_d   = rd_cnt_q;
      gap_d      = gap_q;
      chan_d     = 5'd0;
      data_d     = '0;
      rd_en_d    = 1'b0;
      err_d      = err_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               width_d = layer_width;
               kn_d    = kn_size_mode;
               com_d   = com_type;
               first_d = first_iter;
               err_d   = 1'b0;
               state_d = ST_CFG;
            end
         end
         ST_CFG: begin
            if (calc_err) begin
               err_d   = 1'b1;
               state_d = ST_IDLE;
            end else begin
               wr_total_d = calc_wr_total;
               rd_total_d = calc_rd_total;
               state_d    = ST_WR_RST;
            end
         end
         ST_WR_RST: begin
            wr_cnt_d = '0;
            rd_cnt_d = '0;
            state_d  = ST_WRITE;
         end
         ST_WRITE: begin
            if (res_valid && (wr_cnt_q < wr_total_q)) begin
               data_d   = res_data;
               chan_d   = (com_q == DW_CONV_MODE) ? 5'd1 : (5'(wr_cnt_q[2:0]) + 5'd1);
               wr_cnt_d = wr_cnt_q + CNT_W'(1);
               if ((wr_cnt_q + CNT_W'(1)) == wr_total_q) begin
                  state_d = ST_RD_RST;
               end
            end
         end
         ST_RD_RST: begin
            gap_d   = 1'b0;
            state_d = ST_GAP;
         end
         ST_GAP: begin
            // Two quiet cycles let the buffer's address counter settle after its reset
            if (gap_q) begin
               state_d = ST_READ;
            end else begin
               gap_d = 1'b1;
            end
         end
         ST_READ: begin
            // rd_cnt already counts the strobe on the output, so equality means the last one is out
            if (rd_cnt_q == rd_total_q) begin
               state_d = ST_DONE;
            end else if (rd_ready) begin
               rd_en_d  = 1'b1;
               rd_cnt_d = rd_cnt_q + CNT_W'(1);
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      if (clear) begin
         state_d  = ST_IDLE;
         first_d  = 1'b0;
         wr_cnt_d = '0;
         rd_cnt_d = '0;
         gap_d    = 1'b0;
         chan_d   = 5'd0;
         data_d   = '0;
         rd_en_d  = 1'b0;
         err_d    = err_q;
      end
   end

   assign cnt_rst            = (state_q == ST_WR_RST) || (state_q == ST_RD_RST);
   assign wr_rd_mode         = (state_q == ST_WR_RST) || (state_q == ST_WRITE);
   assign busy               = (state_q != ST_IDLE);
   assign done               = (state_q == ST_DONE);
   assign initial_iteration  = first_q;
   assign current_channel_NO = chan_q;
   assign buf_data_in        = data_q;
   assign rd_out_en          = rd_en_q;
   assign cfg_err            = err_q;

endmodule

// File: tb/tb_output_buffer_ctrl.sv
// tb/tb_output_buffer_ctrl.sv - scoreboard bench for the A-buffer output sequencer
module tb_output_buffer_ctrl;
   import output_buffer_ctrl_pkg::*;

   localparam int FW = FEATURE_WIDTH;
   localparam int BN = A_BUFFER_NUM;
   localparam int DW = FW * BN;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic          clear = 1'b0;
   logic [15:0]   layer_width = '0;
   logic [1:0]    kn_size_mode = '0;
   logic [7:0]    com_type = '0;
   logic          first_iter = 1'b0;
   logic          res_valid = 1'b0;
   logic [DW-1:0] res_data = '0;
   logic          rd_ready = 1'b1;
   logic          cnt_rst;
   logic          initial_iteration;
   logic          wr_rd_mode;
   logic [4:0]    current_channel_NO;
   logic          rd_out_en;
   logic [DW-1:0] buf_data_in;
   logic          busy;
   logic          done;
   logic          cfg_err;

   typedef struct packed {
      logic [4:0]    chan;
      logic [DW-1:0] data;
   } beat_t;

   beat_t sb_q[$];

   int n_pass = 0;
   int n_total = 0;

   int         r_wr, r_sb_bad, r_idle_bad, r_rst_cyc, r_rd, r_stall_strb, r_done, r_done_gap;
   logic [1:0] r_rst_modes;
   logic       r_ii, r_busy_after, r_err_after;
   bit         r_timeout;

   output_buffer_ctrl dut (
      .clk                (clk),
      .rst                (rst),
      .start              (start),
      .clear              (clear),
      .layer_width        (layer_width),
      .kn_size_mode       (kn_size_mode),
      .com_type           (com_type),
      .first_iter         (first_iter),
      .res_valid          (res_valid),
      .res_data           (res_data),
      .rd_ready           (rd_ready),
      .cnt_rst            (cnt_rst),
      .initial_iteration  (initial_iteration),
      .wr_rd_mode         (wr_rd_mode),
      .current_channel_NO (current_channel_NO),
      .rd_out_en          (rd_out_en),
      .buf_data_in        (buf_data_in),
      .busy               (busy),
      .done               (done),
      .cfg_err            (cfg_err)
   );

   always #5 clk = ~clk;

   function automatic logic [DW-1:0] rand_data();
      logic [DW-1:0] d;
      d = '0;
      for (int i = 0; i < (DW + 31) / 32; i++) d = (d << 32) | DW'($urandom);
      return d;
   endfunction

   function automatic void exp_totals(input logic [1:0] kn, input logic [7:0] com, input int w,
                                      output int wr, output int rd);
      int rows;
      int ch;
      rows = (kn == KERNEL_SIZE_3_MODE) ? 4 : 5;
      ch   = (com == 8'h01) ? 8 : 4;
      rd   = rows * ((w + 24) / 25) * ch;
      if (com == 8'h01) wr = (kn == KERNEL_SIZE_5_MODE) ? w * 40 : (kn == KERNEL_SIZE_3_MODE) ? w * 16 : ((w + 4) / 5) * 8;
      else              wr = (kn == KERNEL_SIZE_5_MODE) ? w * 5 : w * 2;
   endfunction

   // Runs one layer: pushes expected beats as they are driven, pops them as tagged beats appear
   task automatic run_layer(input logic [1:0] kn, input logic [7:0] com, input logic [15:0] w,
                            input bit toggle, input int stall_at, input int stall_len, input bit poke_start);
      int exp_wr, exp_rd, pushed, j, last_j, done_j, stall_left;
      bit drove_idle, prev_rdy, seen_done, stalled, fin, inject;
      beat_t eb, gb;
      logic [DW-1:0] d;
      exp_totals(kn, com, int'(w), exp_wr, exp_rd);
      sb_q.delete();
      r_wr = 0; r_sb_bad = 0; r_idle_bad = 0; r_rst_cyc = 0; r_rd = 0; r_stall_strb = 0; r_done = 0;
      r_rst_modes = 2'b00; r_ii = 1'b0; r_busy_after = 1'b1; r_err_after = 1'b1; r_timeout = 1'b0;
      pushed = 0; j = 0; last_j = -1; done_j = -1; stall_left = 0;
      drove_idle = 0; prev_rdy = 1; seen_done = 0; stalled = 0; fin = 0; inject = 0;
      rd_ready = 1'b1;
      res_valid = 1'b0;
      @(negedge clk);
      kn_size_mode = kn; com_type = com; layer_width = w; first_iter = 1'b1; start = 1'b1;
      @(negedge clk);
      start = 1'b0; first_iter = 1'b0;
      while (!fin) begin
         if (cnt_rst) begin
            r_rst_cyc++;
            r_rst_modes = {r_rst_modes[0], wr_rd_mode};
         end
         if (j == 2) r_ii = initial_iteration;
         if (current_channel_NO != 5'd0) begin
            r_wr++;
            gb = {current_channel_NO, buf_data_in};
            if (sb_q.size() == 0) r_sb_bad++;
            else begin
               eb = sb_q.pop_front();
               if (gb !== eb) r_sb_bad++;
            end
         end else if (buf_data_in !== '0) begin
            r_idle_bad++;
         end
         if (drove_idle && current_channel_NO !== 5'd0) r_idle_bad++;
         if (rd_out_en) begin
            r_rd++;
            last_j = j;
            if (!prev_rdy) r_stall_strb++;
            if (poke_start && r_rd == 3) inject = 1;
         end
         if (done) begin
            r_done++;
            if (!seen_done) done_j = j;
            seen_done = 1;
         end
         if (seen_done && j == done_j + 1) begin
            r_busy_after = busy;
            r_err_after = cfg_err;
            fin = 1;
         end else if (j >= 4000) begin
            r_timeout = 1;
            fin = 1;
         end
         start = 1'b0;
         com_type = com;
         drove_idle = 0;
         if (inject) begin
            start = 1'b1;
            com_type = 8'h03;
            inject = 0;
         end
         if (j >= 2 && pushed < exp_wr) begin
            if (!toggle || ((j - 2) % 2 == 0)) begin
               d = rand_data();
               res_valid = 1'b1;
               res_data = d;
               sb_q.push_back({(com == 8'h02) ? 5'd1 : 5'((pushed % 8) + 1), d});
               pushed++;
            end else begin
               res_valid = 1'b0;
               res_data = rand_data();
               drove_idle = 1;
            end
         end else begin
            res_valid = !toggle;
            res_data = rand_data();
         end
         if (stall_at >= 0 && !stalled && r_rd == stall_at) begin
            stalled = 1;
            stall_left = stall_len;
         end
         if (stall_left > 0) begin
            rd_ready = 1'b0;
            stall_left--;
         end else begin
            rd_ready = 1'b1;
         end
         prev_rdy = rd_ready;
         j++;
         @(negedge clk);
      end
      res_valid = 1'b0;
      start = 1'b0;
      rd_ready = 1'b1;
      r_done_gap = done_j - last_j;
   endtask

   task automatic test_reset();
      #2 rst = 1'b0;
      @(negedge clk);
      n_total++;
      if ({cnt_rst, initial_iteration, wr_rd_mode, current_channel_NO, rd_out_en, busy, done, cfg_err} !== 12'd0 || buf_data_in !== '0)
         $display("FAIL reset_outputs got busy=%0b chan=%0d cnt_rst=%0b cfg_err=%0b exp all 0", busy, current_channel_NO, cnt_rst, cfg_err);
      else n_pass++;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      n_total++;
      if (busy !== 1'b0 || wr_rd_mode !== 1'b0) $display("FAIL reset_release_idle got busy=%0b mode=%0b exp 0 0", busy, wr_rd_mode);
      else n_pass++;
   endtask

   task automatic test_conv1();
      run_layer(KERNEL_SIZE_1_MODE, 8'h01, 16'd28, 1'b0, -1, 0, 1'b0);
      n_total++; if (r_timeout !== 1'b0) $display("FAIL conv1_timeout got=%0b exp=0", r_timeout); else n_pass++;
      n_total++; if (r_wr !== 48) $display("FAIL conv1_wr_beats got=%0d exp=48", r_wr); else n_pass++;
      n_total++; if (r_sb_bad !== 0 || sb_q.size() !== 0) $display("FAIL conv1_scoreboard got bad=%0d left=%0d exp 0 0", r_sb_bad, sb_q.size()); else n_pass++;
      n_total++; if (r_rst_cyc !== 2 || r_rst_modes !== 2'b10) $display("FAIL conv1_cnt_rst got cycles=%0d modes=%b exp 2 10", r_rst_cyc, r_rst_modes); else n_pass++;
      n_total++; if (r_rd !== 80) $display("FAIL conv1_rd_strobes got=%0d exp=80", r_rd); else n_pass++;
      n_total++; if (r_done !== 1 || r_done_gap !== 1) $display("FAIL conv1_done got pulses=%0d gap=%0d exp 1 1", r_done, r_done_gap); else n_pass++;
      n_total++; if (r_ii !== 1'b1) $display("FAIL conv1_initial_iteration got=%0b exp=1", r_ii); else n_pass++;
      n_total++; if (r_busy_after !== 1'b0 || r_idle_bad !== 0) $display("FAIL conv1_idle_after got busy=%0b idle_bad=%0d exp 0 0", r_busy_after, r_idle_bad); else n_pass++;
   endtask

   task automatic test_conv3_toggle();
      run_layer(KERNEL_SIZE_3_MODE, 8'h01, 16'd28, 1'b1, -1, 0, 1'b0);
      n_total++; if (r_timeout !== 1'b0) $display("FAIL conv3_timeout got=%0b exp=0", r_timeout); else n_pass++;
      n_total++; if (r_wr !== 448) $display("FAIL conv3_wr_beats got=%0d exp=448", r_wr); else n_pass++;
      n_total++; if (r_sb_bad !== 0) $display("FAIL conv3_scoreboard got bad=%0d exp=0", r_sb_bad); else n_pass++;
      n_total++; if (r_idle_bad !== 0) $display("FAIL conv3_idle_tag got bad=%0d exp=0", r_idle_bad); else n_pass++;
      n_total++; if (r_rd !== 64) $display("FAIL conv3_rd_strobes got=%0d exp=64", r_rd); else n_pass++;
   endtask

   task automatic test_dw5_stall();
      run_layer(KERNEL_SIZE_5_MODE, 8'h02, 16'd28, 1'b0, 10, 10, 1'b0);
      n_total++; if (r_timeout !== 1'b0) $display("FAIL dw5_timeout got=%0b exp=0", r_timeout); else n_pass++;
      n_total++; if (r_wr !== 140 || r_sb_bad !== 0) $display("FAIL dw5_writes got beats=%0d bad=%0d exp 140 0", r_wr, r_sb_bad); else n_pass++;
      n_total++; if (r_rd !== 40) $display("FAIL dw5_rd_strobes got=%0d exp=40", r_rd); else n_pass++;
      n_total++; if (r_stall_strb !== 0) $display("FAIL dw5_stall_strobes got=%0d exp=0", r_stall_strb); else n_pass++;
      n_total++; if (r_done !== 1 || r_done_gap !== 1) $display("FAIL dw5_done got pulses=%0d gap=%0d exp 1 1", r_done, r_done_gap); else n_pass++;
   endtask

   task automatic test_cfg_err();
      logic [7:0]  ec [3];
      logic [1:0]  ek [3];
      logic [15:0] ew [3];
      logic        saw_rst;
      logic        busy_cfg;
      ec[0] = 8'h03; ek[0] = KERNEL_SIZE_5_MODE; ew[0] = 16'd28;
      ec[1] = 8'h02; ek[1] = KERNEL_SIZE_1_MODE; ew[1] = 16'd28;
      ec[2] = 8'h01; ek[2] = KERNEL_SIZE_1_MODE; ew[2] = 16'd0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         com_type = ec[i]; kn_size_mode = ek[i]; layer_width = ew[i]; start = 1'b1;
         @(negedge clk);
         start = 1'b0;
         saw_rst = cnt_rst;
         busy_cfg = busy;
         @(negedge clk);
         saw_rst = saw_rst | cnt_rst;
         n_total++;
         if (busy_cfg !== 1'b1 || busy !== 1'b0 || cfg_err !== 1'b1)
            $display("FAIL cfg_err_%0d got busy_cfg=%0b busy=%0b cfg_err=%0b exp 1 0 1", i, busy_cfg, busy, cfg_err);
         else n_pass++;
         repeat (3) begin
            @(negedge clk);
            saw_rst = saw_rst | cnt_rst;
         end
         n_total++;
         if (saw_rst !== 1'b0) $display("FAIL cfg_err_no_cnt_rst_%0d got=%0b exp=0", i, saw_rst); else n_pass++;
      end
      run_layer(KERNEL_SIZE_1_MODE, 8'h01, 16'd28, 1'b0, -1, 0, 1'b0);
      n_total++;
      if (r_err_after !== 1'b0 || r_wr !== 48 || r_rd !== 80)
         $display("FAIL cfg_err_recover got err=%0b wr=%0d rd=%0d exp 0 48 80", r_err_after, r_wr, r_rd);
      else n_pass++;
   endtask

   task automatic test_async_reset();
      int beats;
      int cyc;
      @(negedge clk);
      com_type = 8'h01; kn_size_mode = KERNEL_SIZE_1_MODE; layer_width = 16'd28; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      res_valid = 1'b1;
      beats = 0;
      cyc = 0;
      while (beats < 20 && cyc < 200) begin
         @(negedge clk);
         if (current_channel_NO != 5'd0) beats++;
         res_data = rand_data();
         cyc++;
      end
      n_total++;
      if (beats !== 20) $display("FAIL async_rst_reach_beat got=%0d exp=20", beats); else n_pass++;
      #2 rst = 1'b0;
      #1;
      n_total++;
      if ({cnt_rst, initial_iteration, wr_rd_mode, current_channel_NO, rd_out_en, busy, done, cfg_err} !== 12'd0 || buf_data_in !== '0)
         $display("FAIL async_rst_outputs got busy=%0b chan=%0d mode=%0b exp all 0", busy, current_channel_NO, wr_rd_mode);
      else n_pass++;
      res_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      run_layer(KERNEL_SIZE_1_MODE, 8'h01, 16'd28, 1'b0, -1, 0, 1'b0);
      n_total++;
      if (r_timeout !== 1'b0 || r_wr !== 48 || r_rd !== 80 || r_sb_bad !== 0)
         $display("FAIL async_rst_rerun got wr=%0d rd=%0d bad=%0d exp 48 80 0", r_wr, r_rd, r_sb_bad);
      else n_pass++;
   endtask

   task automatic test_start_clear();
      int beats;
      int cyc;
      logic saw;
      run_layer(KERNEL_SIZE_1_MODE, 8'h01, 16'd28, 1'b0, -1, 0, 1'b1);
      n_total++;
      if (r_rd !== 80 || r_done !== 1 || r_err_after !== 1'b0 || r_timeout !== 1'b0)
         $display("FAIL start_in_read got rd=%0d done=%0d err=%0b exp 80 1 0", r_rd, r_done, r_err_after);
      else n_pass++;
      @(negedge clk);
      com_type = 8'h01; kn_size_mode = KERNEL_SIZE_1_MODE; layer_width = 16'd28; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      res_valid = 1'b1;
      beats = 0;
      cyc = 0;
      while (beats < 10 && cyc < 200) begin
         @(negedge clk);
         if (current_channel_NO != 5'd0) beats++;
         res_data = rand_data();
         cyc++;
      end
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      n_total++;
      if (busy !== 1'b0 || current_channel_NO !== 5'd0 || buf_data_in !== '0 || wr_rd_mode !== 1'b0)
         $display("FAIL clear_to_idle got busy=%0b chan=%0d mode=%0b exp 0 0 0", busy, current_channel_NO, wr_rd_mode);
      else n_pass++;
      saw = 1'b0;
      repeat (20) begin
         @(negedge clk);
         if (done || busy || current_channel_NO != 5'd0 || rd_out_en) saw = 1'b1;
      end
      res_valid = 1'b0;
      n_total++;
      if (saw !== 1'b0) $display("FAIL clear_quiet got activity=%0b exp=0", saw); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_conv1();
      test_conv3_toggle();
      test_dw5_stall();
      test_cfg_err();
      test_async_reset();
      test_start_clear();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/output_buffer_ctrl.md
Name: output_buffer_ctrl

Overview:
- Sequencer for the A-buffer output path (`output_module`).
- Latches one layer's configuration on `start` and computes write and read beat totals.
- Runs a write phase: each PE result beat is tagged with a channel number and forwarded, registered, to the buffer. Then a read/drain phase under downstream flow control.
- Sits between the PE array result bus and `output_module`, and drives that module's `cnt_rst`, `wr_rd_mode`, `current_channel_NO`, `rd_out_en` and `initial_iteration`.

Parameters:
- FEATURE_WIDTH, `FEATURE_WIDTH`, bits per feature element.
- BUFFER_NUM, `A_BUFFER_NUM`, number of parallel A-buffer banks (25).
- CNT_W, 24, beat counter width (covers 65535*40).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset (asserted at 0).
- start  in  1  one-cycle pulse; begins a layer. Ignored unless in IDLE.
- clear  in  1  synchronous abort to IDLE.
- layer_width  in  16  feature-map width.
- kn_size_mode  in  2  KERNEL_SIZE_5/3/1_MODE.
- com_type  in  8  8'h01 normal conv, 8'h02 depthwise.
- first_iter  in  1  latched; drives `initial_iteration`.
- res_valid  in  1  PE result beat valid.
- res_data  in  BUFFER_NUM*FEATURE_WIDTH  PE result beat.
- rd_ready  in  1  downstream accepts a read beat this cycle.
- cnt_rst  out  1  to `output_module`.
- initial_iteration  out  1  to `output_module`.
- wr_rd_mode  out  1  1 = write, 0 = read.
- current_channel_NO  out  5  channel tag; 0 = no write.
- rd_out_en  out  1  read strobe.
- buf_data_in  out  BUFFER_NUM*FEATURE_WIDTH  registered `res_data`.
- busy  out  1  high when not in IDLE.
- done  out  1  one-cycle pulse at end of read phase.
- cfg_err  out  1  sticky until next accepted `start`.

Behaviour:
- Reset values: all outputs 0, state IDLE, counters 0.
- Async reset takes effect mid-operation immediately; no beat completes.

Beat totals, computed in CFG:
- W = `layer_width`; R = 4 if KERNEL_SIZE_3_MODE, else 5; C = 8 for conv, 4 for depthwise.
- Write totals:
  - CONV_5: W*5*8
  - CONV_3: W*2*8
  - DW_5: W*5
  - DW_3: W*2
  - CONV_1: ceil(W/5)*8
- Read total: R*ceil(W/25)*C.
- Division is by constants; computed combinationally in the single CFG cycle.

Configuration errors:
- Error cases: `com_type` not 01/02, depthwise with KERNEL_SIZE_1, W = 0.
- On error: `cfg_err` = 1, return to IDLE, `cnt_rst` is never asserted.

FSM:
- IDLE -> CFG on `start`. Latch config and `first_iter`.
- CFG -> WR_RST (or IDLE on error).
- WR_RST: `cnt_rst` = 1 and `wr_rd_mode` = 1 for exactly one cycle -> WRITE.
- WRITE, entered with `wr_cnt` = 0:
  - A `res_valid` beat in cycle N gives, at N+1: `buf_data_in` = `res_data`, and `current_channel_NO` = (`wr_cnt` mod 8)+1 for conv or 1 for depthwise. `wr_cnt` increments.
  - Without `res_valid`: `current_channel_NO` = 0 and `buf_data_in` = 0 next cycle.
  - The beat that makes `wr_cnt` = write total -> RD_RST.
- RD_RST: `wr_rd_mode` = 0, `cnt_rst` = 1 for one cycle -> GAP.
- GAP: 2 idle cycles (buffer counter settle) -> READ.
- READ:
  - `rd_out_en` = 1 in the cycle after `rd_ready` is seen high, when `rd_cnt` < read total. `rd_cnt` increments per strobe.
  - No strobe while `rd_ready` = 0.
  - Last strobe -> DONE.
- DONE: `done` = 1 for one cycle -> IDLE. `wr_rd_mode` stays 0.

Boundary and concurrency rules:
- `res_valid` outside WRITE: ignored; no channel tag is produced.
- `res_valid` arriving on the final write beat's cycle+1 is dropped; the producer is responsible for not sending extra beats.
- `start` while busy: ignored.
- `clear` has priority over every transition. It drives IDLE next cycle with outputs 0 except `cfg_err`.
- Counters saturate at their totals; no wrap.

Decomposition:
- Mode encodings, NORMAL_CONV_MODE/DW_CONV_MODE, kernel-mode constants, FEATURE_WIDTH and A_BUFFER_NUM stay in the shared `network_para.vh`.
- Add to it: the FSM state encoding and ROW_NUM_3/ROW_NUM_5, CH_NUM_CONV/CH_NUM_DW.
- One sub-module: `obuf_beat_calc`, purely combinational: (W, kn_size_mode, com_type) -> write total, read total, error.

Test Plan:
- CONV_1, W = 28, `res_valid` held high:
  - exactly 48 write beats, channel tags cycling 1..8 six times;
  - `cnt_rst` pulses before WRITE and before READ;
  - 80 `rd_out_en` strobes with `rd_ready` = 1;
  - `done` one cycle after the last strobe.
- CONV_3, W = 28: 448 writes, 64 reads; `res_valid` toggling 1/0 gives `current_channel_NO` = 0 on every idle cycle.
- DW_5, W = 28: 140 writes all tagged 1, 40 reads. `rd_ready` low for 10 cycles mid-read -> no strobes and `rd_cnt` frozen.
- `com_type` = 8'h03 -> `cfg_err` = 1, `busy` back to 0 two cycles after `start`, `cnt_rst` never asserted. A valid `start` afterwards clears `cfg_err`.
- `rst` driven low in WRITE at beat 20 -> all outputs 0 asynchronously. After release, `start` runs a full CONV_1 W = 28 layer correctly (48/80).
- `start` during READ ignored. `clear` during WRITE -> IDLE next cycle, `current_channel_NO` = 0, no `done` pulse.
